sprite_pixel_fetch: RTL

- Upstream and downstream companion of the 584x167 sprite colour ROM (1-cycle registered read, row/col addressed).
- Takes the VGA sync counters and a sprite origin, and drives the ROM row/col. Aligns the ROM colour with delayed video_on and in-box flags.
- Outputs the final 12-bit RGB pixel, with a colour key and background fill, to the VGA output register stage.

---
 rtl/sprite_pixel_fetch_if.sv | 26 ++
 rtl/sprite_pixel_fetch.sv | 103 ++++++++++
 2 files changed

// File: rtl/sprite_pixel_fetch_if.sv
// Bundle of the sync-counter, sprite-origin, colour-ROM and pixel-output signals
// that pass between the sprite fetch stage and its neighbours.
interface sprite_pixel_fetch_if;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        video_on;
  logic        frame_start;
  logic [9:0]  pos_x;
  logic [9:0]  pos_y;
  logic        enable;
  logic [7:0]  rom_row;
  logic [9:0]  rom_col;
  logic [11:0] rom_data;
  logic [11:0] rgb;
  logic        sprite_hit;

  modport slave (
    input  x, y, video_on, frame_start, pos_x, pos_y, enable, rom_data,
    output rom_row, rom_col, rgb, sprite_hit
  );

  modport master (
    output x, y, video_on, frame_start, pos_x, pos_y, enable, rom_data,
    input  rom_row, rom_col, rgb, sprite_hit
  );
endinterface

// File: rtl/sprite_pixel_fetch.sv
// Sprite box test, colour-ROM addressing and 2-cycle pixel pipeline with colour key.
// Optional blink (6-bit frame counter hiding the sprite) enabled by SPRITE_BLINK_EN.
module sprite_pixel_fetch #(
  parameter int          SPRITE_W  = 584,
  parameter int          SPRITE_H  = 167,
  parameter logic [11:0] BG_COLOR  = 12'h000,
  parameter logic [11:0] KEY_COLOR = 12'hF0F,
  parameter int          BLINK_BIT = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sprite_pixel_fetch_if.slave  bus
);

  logic [9:0]  pos_x_q, pos_x_d;
  logic [9:0]  pos_y_q, pos_y_d;
  logic        en_q, en_d;
  logic        in_box_q, in_box_d;
  logic        von_q, von_d;
  logic [11:0] rgb_q, rgb_d;
  logic        hit_q, hit_d;
  logic        visible;
  logic        in_box;
  logic [10:0] x_end, y_end;

`ifdef SPRITE_BLINK_EN
  logic [5:0]  cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (bus.frame_start) cnt_d = cnt_q + 6'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign visible = en_q & ~cnt_q[BLINK_BIT];
`else
  assign visible = en_q;
`endif

  // Origin only moves at frame_start so a frame never tears.
  always_comb begin
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    en_d    = en_q;
    if (bus.frame_start) begin
      pos_x_d = bus.pos_x;
      pos_y_d = bus.pos_y;
      en_d    = bus.enable;
    end
  end

  // 11-bit compares: the box end can reach 1023+584 without wrapping.
  assign x_end  = {1'b0, pos_x_q} + 11'(SPRITE_W);
  assign y_end  = {1'b0, pos_y_q} + 11'(SPRITE_H);
  assign in_box = visible
                & ({1'b0, bus.x} >= {1'b0, pos_x_q}) & ({1'b0, bus.x} < x_end)
                & ({1'b0, bus.y} >= {1'b0, pos_y_q}) & ({1'b0, bus.y} < y_end);

  assign bus.rom_col = in_box ? (bus.x - pos_x_q) : 10'd0;
  assign bus.rom_row = in_box ? 8'(bus.y - pos_y_q) : 8'd0;

  assign in_box_d = in_box;
  assign von_d    = bus.video_on;

  always_comb begin
    rgb_d = BG_COLOR;
    hit_d = 1'b0;
    if (!von_q) begin
      rgb_d = 12'h000;
    end else if (in_box_q && (bus.rom_data != KEY_COLOR)) begin
      rgb_d = bus.rom_data;
      hit_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_x_q  <= '0;
      pos_y_q  <= '0;
      en_q     <= 1'b0;
      in_box_q <= 1'b0;
      von_q    <= 1'b0;
      rgb_q    <= '0;
      hit_q    <= 1'b0;
    end else begin
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
      en_q     <= en_d;
      in_box_q <= in_box_d;
      von_q    <= von_d;
      rgb_q    <= rgb_d;
      hit_q    <= hit_d;
    end
  end

  assign bus.rgb        = rgb_q;
  assign bus.sprite_hit = hit_q;

endmodule
